// File: rtl/gf180mcu_fd_sc_mcu9t5v0__scanctl_1.sv
// Scan-test controller: serially loads a pattern into a mux2 scan chain, pulses
// one functional capture, then unloads the chain response into RESP.
module gf180mcu_fd_sc_mcu9t5v0__scanctl_1 #(
  parameter int CHAIN_LEN = 8,
  parameter int CW        = $clog2(CHAIN_LEN + 1)
) (
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 START,
  input  logic [CHAIN_LEN-1:0] PAT,
  input  logic                 SDI,
  output logic                 S,
  output logic                 SDO,
  output logic                 CAP,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [CHAIN_LEN-1:0] RESP,
  inout  wire                  VDD,
  inout  wire                  VSS
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CAPTURE,
    UNLOAD,
    FIN
  } state_e;

  localparam logic [CW-1:0] CNT_LAST = CW'(CHAIN_LEN - 1);

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CHAIN_LEN-1:0] sr_q, sr_d;
  logic [CHAIN_LEN-1:0] resp_q, resp_d;
  logic                 s_q, s_d;
  logic                 sdo_q, sdo_d;
  logic                 cap_q, cap_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  // Supply pins carry no logic; tie them off so they are visibly consumed.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    resp_d  = resp_q;
    sdo_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = LOAD;
          cnt_d   = '0;
          sdo_d   = PAT[0];
          sr_d    = PAT >> 1;
        end
      end
      LOAD: begin
        if (cnt_q == CNT_LAST) begin
          state_d = CAPTURE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
          sdo_d = sr_q[0];
          sr_d  = sr_q >> 1;
        end
      end
      CAPTURE: begin
        state_d = UNLOAD;
        cnt_d   = '0;
      end
      UNLOAD: begin
        // First bit received ends up in RESP[0] after CHAIN_LEN shifts.
        resp_d = {SDI, resp_q[CHAIN_LEN-1:1]};
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state and registered, so they are glitch-free.
    s_d    = (state_d == LOAD) || (state_d == UNLOAD);
    cap_d  = (state_d == CAPTURE);
    busy_d = (state_d != IDLE);
    done_d = (state_d == FIN);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      // NOTE: the response register is cleared on reset; a stale RESP would look valid.
      resp_q  <= '0;
      s_q     <= 1'b0;
      sdo_q   <= 1'b0;
      cap_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      resp_q  <= resp_d;
      s_q     <= s_d;
      sdo_q   <= sdo_d;
      cap_q   <= cap_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign S    = s_q;
  assign SDO  = sdo_q;
  assign CAP  = cap_q;
  assign BUSY = busy_q;
  assign DONE = done_q;
  assign RESP = resp_q;

endmodule
